// File: rtl/game_flow_ctrl.sv
// Game sequencer: coin/credit handling, TITLE->PLAY->GAMEOVER flow, and renderer selection.
// Coin and start decisions take effect 2 cycles after the input rises. screen_sel updates only at frame start.
module game_flow_ctrl #(
    parameter int unsigned COIN_ANIM_CYCLES = 15000000,
    parameter int unsigned SEC_CYCLES       = 33000000,
    parameter int unsigned CONTINUE_SECS    = 9,
    parameter int unsigned MAX_CREDITS      = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x_cnt,
    input  logic [9:0]  y_cnt,
    input  logic        coin_in,
    input  logic        start_req,
    input  logic        player_dead,
    input  logic        mode_arcade,
    output logic        e_piece,
    output logic [3:0]  credits,
    output logic        game_run,
    output logic        new_game,
    output logic        continue_game,
    output logic [1:0]  screen_sel,
    output logic [3:0]  continue_sec
);

    typedef enum logic [1:0] {
        S_TITLE    = 2'b00,
        S_PLAY     = 2'b01,
        S_GAMEOVER = 2'b10
    } state_t;

    localparam logic [3:0]  MAX_C     = 4'(MAX_CREDITS);
    localparam logic [3:0]  CONT_INIT = 4'(CONTINUE_SECS);
    localparam logic [31:0] ANIM_END  = 32'(COIN_ANIM_CYCLES);
    localparam logic [31:0] SEC_END   = 32'(SEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic        coin_q, start_q;
    logic        coin_ev_q, start_ev_q;
    logic        anim_busy_q, anim_busy_d;
    logic [31:0] anim_cnt_q, anim_cnt_d;
    logic [31:0] sec_cnt_q, sec_cnt_d;
    logic [3:0]  credits_q, credits_d;
    logic [3:0]  cont_q, cont_d;
    logic        e_piece_q;
    logic        new_game_q, new_game_d;
    logic        cont_game_q, cont_game_d;
    logic        game_run_q;
    logic [1:0]  screen_q, screen_d;
    logic [1:0]  screen_tgt;

    logic coin_ok;
    logic can_start;
    logic consume;
    logic sec_wrap;

    // Start permission looks at the credit count before this cycle's coin lands.
    assign coin_ok   = coin_ev_q & mode_arcade & ~anim_busy_q & (credits_q < MAX_C);
    assign can_start = ~mode_arcade | (credits_q != 4'd0);
    assign sec_wrap  = (sec_cnt_q == SEC_END);

    always_comb begin
        anim_busy_d = anim_busy_q;
        anim_cnt_d  = anim_cnt_q;
        if (coin_ok) begin
            anim_busy_d = 1'b1;
            anim_cnt_d  = 32'd0;
        end else if (anim_busy_q) begin
            if (anim_cnt_q == ANIM_END) begin
                anim_busy_d = 1'b0;
                anim_cnt_d  = 32'd0;
            end else begin
                anim_cnt_d  = anim_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cont_d      = cont_q;
        sec_cnt_d   = sec_cnt_q;
        new_game_d  = 1'b0;
        cont_game_d = 1'b0;
        consume     = 1'b0;
        case (state_q)
            S_TITLE: begin
                if (start_ev_q && can_start) begin
                    state_d    = S_PLAY;
                    new_game_d = 1'b1;
                    consume    = mode_arcade;
                end
            end
            S_PLAY: begin
                if (player_dead) begin
                    state_d   = S_GAMEOVER;
                    cont_d    = CONT_INIT;
                    sec_cnt_d = 32'd0;
                end
            end
            S_GAMEOVER: begin
                sec_cnt_d = sec_wrap ? 32'd0 : sec_cnt_q + 32'd1;
                // A continue request beats the countdown expiring in the same cycle.
                if (start_ev_q && can_start) begin
                    state_d     = S_PLAY;
                    cont_game_d = 1'b1;
                    consume     = mode_arcade;
                end else if (sec_wrap) begin
                    if (cont_q == 4'd0) begin
                        state_d = S_TITLE;
                    end else begin
                        cont_d  = cont_q - 4'd1;
                    end
                end
            end
            default: state_d = S_TITLE;
        endcase
    end

    assign credits_d = credits_q + {3'b000, coin_ok} - {3'b000, consume};

    always_comb begin
        case (state_q)
            S_PLAY:     screen_tgt = 2'b01;
            S_GAMEOVER: screen_tgt = 2'b10;
            default:    screen_tgt = 2'b00;
        endcase
    end

    assign screen_d = ((x_cnt == 11'd0) && (y_cnt == 10'd0)) ? screen_tgt : screen_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_TITLE;
            coin_q      <= 1'b0;
            start_q     <= 1'b0;
            coin_ev_q   <= 1'b0;
            start_ev_q  <= 1'b0;
            anim_busy_q <= 1'b0;
            anim_cnt_q  <= 32'd0;
            sec_cnt_q   <= 32'd0;
            credits_q   <= 4'd0;
            cont_q      <= 4'd0;
            e_piece_q   <= 1'b0;
            new_game_q  <= 1'b0;
            cont_game_q <= 1'b0;
            game_run_q  <= 1'b0;
            screen_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            coin_q      <= coin_in;
            start_q     <= start_req;
            coin_ev_q   <= coin_in & ~coin_q;
            start_ev_q  <= start_req & ~start_q;
            anim_busy_q <= anim_busy_d;
            anim_cnt_q  <= anim_cnt_d;
            sec_cnt_q   <= sec_cnt_d;
            credits_q   <= credits_d;
            cont_q      <= cont_d;
            e_piece_q   <= coin_ok;
            new_game_q  <= new_game_d;
            cont_game_q <= cont_game_d;
            game_run_q  <= (state_d == S_PLAY);
            screen_q    <= screen_d;
        end
    end

    assign e_piece       = e_piece_q;
    assign credits       = credits_q;
    assign game_run      = game_run_q;
    assign new_game      = new_game_q;
    assign continue_game = cont_game_q;
    assign screen_sel    = screen_q;
    assign continue_sec  = cont_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl with small timing parameters and a 16x8 frame.
module tb_game_flow_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x_cnt = 11'd0;
    logic [9:0]  y_cnt = 10'd0;
    logic        coin_in, start_req, player_dead, mode_arcade;
    logic        e_piece, game_run, new_game, continue_game;
    logic [3:0]  credits, continue_sec;
    logic [1:0]  screen_sel;

    int checks = 0;
    int errors = 0;
    int ep_cnt = 0;
    int ng_cnt = 0;
    int cg_cnt = 0;
    logic [3:0] exp_q[$];

    game_flow_ctrl #(
        .COIN_ANIM_CYCLES(10),
        .SEC_CYCLES(20),
        .CONTINUE_SECS(3),
        .MAX_CREDITS(2)
    ) dut (
        .clk(clk), .reset(reset), .x_cnt(x_cnt), .y_cnt(y_cnt),
        .coin_in(coin_in), .start_req(start_req), .player_dead(player_dead),
        .mode_arcade(mode_arcade), .e_piece(e_piece), .credits(credits),
        .game_run(game_run), .new_game(new_game), .continue_game(continue_game),
        .screen_sel(screen_sel), .continue_sec(continue_sec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (x_cnt == 11'd15) begin
            x_cnt <= 11'd0;
            y_cnt <= (y_cnt == 10'd7) ? 10'd0 : y_cnt + 10'd1;
        end else begin
            x_cnt <= x_cnt + 11'd1;
        end
    end

    // Advance one cycle; every e_piece pulse is matched against the expected credit queue.
    task automatic tick();
        logic [3:0] exp_c;
        @(posedge clk);
        @(negedge clk);
        if (e_piece === 1'b1) begin
            ep_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL e_piece_unexpected credits=%0d", credits);
            end else begin
                exp_c = exp_q.pop_front();
                if (credits !== exp_c) begin
                    errors++;
                    $display("FAIL e_piece_credits got=%0d exp=%0d", credits, exp_c);
                end
            end
        end
        if (new_game === 1'b1) ng_cnt++;
        if (continue_game === 1'b1) cg_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic coin_pulse();
        coin_in = 1'b1;
        tick();
        coin_in = 1'b0;
        tick();
    endtask

    task automatic start_pulse();
        start_req = 1'b1;
        tick();
        start_req = 1'b0;
        tick();
    endtask

    task automatic wait_sof(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (x_cnt == 11'd0 && y_cnt == 10'd0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({e_piece, credits, game_run, new_game, continue_game, screen_sel, continue_sec} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {e_piece, credits, game_run, new_game, continue_game, screen_sel, continue_sec});
        end
        reset = 1'b0;
    endtask

    task automatic test_coin_hold();
        int ep0;
        do_reset();
        mode_arcade = 1'b1;
        ep0 = ep_cnt;
        exp_q.push_back(4'd1);
        coin_in = 1'b1;
        repeat (30) tick();
        coin_in = 1'b0;
        tick();
        checks++;
        if (ep_cnt - ep0 !== 1) begin
            errors++; $display("FAIL hold_pulses got=%0d exp=1", ep_cnt - ep0);
        end
        checks++;
        if (credits !== 4'd1) begin
            errors++; $display("FAIL hold_credits got=%0d exp=1", credits);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL hold_missing_pulse left=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_coin_lockout();
        int ep0;
        do_reset();
        ep0 = ep_cnt;
        exp_q.push_back(4'd1);
        coin_pulse();
        repeat (3) tick();
        coin_pulse();
        checks++;
        if (credits !== 4'd1) begin
            errors++; $display("FAIL lockout_busy credits got=%0d exp=1", credits);
        end
        repeat (10) tick();
        exp_q.push_back(4'd2);
        coin_pulse();
        repeat (15) tick();
        coin_pulse();
        repeat (15) tick();
        checks++;
        if (credits !== 4'd2) begin
            errors++; $display("FAIL lockout_max credits got=%0d exp=2", credits);
        end
        checks++;
        if (ep_cnt - ep0 !== 2 || exp_q.size() != 0) begin
            errors++; $display("FAIL lockout_pulses got=%0d exp=2", ep_cnt - ep0);
            exp_q.delete();
        end
    endtask

    task automatic test_start_gate();
        int ng0;
        bit found;
        do_reset();
        ng0 = ng_cnt;
        start_pulse();
        repeat (5) tick();
        checks++;
        if (game_run !== 1'b0 || ng_cnt != ng0) begin
            errors++; $display("FAIL start_no_credit game_run=%b new_game_cycles=%0d exp 0/0", game_run, ng_cnt - ng0);
        end
        exp_q.push_back(4'd1);
        coin_pulse();
        repeat (15) tick();
        start_pulse();
        checks++;
        if (ng_cnt - ng0 !== 1 || game_run !== 1'b1 || credits !== 4'd0) begin
            errors++; $display("FAIL start_new_game ng=%0d run=%b credits=%0d exp 1/1/0", ng_cnt - ng0, game_run, credits);
        end
        checks++;
        if (screen_sel !== 2'b00) begin
            errors++; $display("FAIL start_screen_early got=%b exp=00", screen_sel);
        end
        tick();
        checks++;
        if (ng_cnt - ng0 !== 1) begin
            errors++; $display("FAIL new_game_width got=%0d exp=1", ng_cnt - ng0);
        end
        wait_sof(found);
        checks++;
        if (!found) begin
            errors++; $display("FAIL sof_timeout got=0 exp=1");
        end
        checks++;
        if (screen_sel !== 2'b00) begin
            errors++; $display("FAIL screen_hold got=%b exp=00", screen_sel);
        end
        tick();
        checks++;
        if (screen_sel !== 2'b01) begin
            errors++; $display("FAIL screen_game got=%b exp=01", screen_sel);
        end
    endtask

    task automatic test_countdown();
        bit prev_b, saw, found;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (x_cnt == 11'd10 && y_cnt == 10'd7) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL align_timeout got=0 exp=1");
        end
        player_dead = 1'b1;
        tick();
        player_dead = 1'b0;
        checks++;
        if (continue_sec !== 4'd3 || game_run !== 1'b0) begin
            errors++; $display("FAIL gameover_entry sec=%0d run=%b exp 3/0", continue_sec, game_run);
        end
        prev_b = 1'b0;
        saw = 1'b0;
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (prev_b && !saw) begin
                saw = 1'b1;
                checks++;
                if (screen_sel !== 2'b10) begin
                    errors++; $display("FAIL screen_gameover got=%b exp=10", screen_sel);
                end
            end
            prev_b = (x_cnt == 11'd0 && y_cnt == 10'd0);
            if (t == 20 || t == 40 || t == 60) begin
                checks++;
                if (continue_sec !== 4'(3 - t / 20)) begin
                    errors++; $display("FAIL countdown t=%0d got=%0d exp=%0d", t, continue_sec, 3 - t / 20);
                end
            end
        end
        checks++;
        if (!saw || game_run !== 1'b0) begin
            errors++; $display("FAIL countdown_end saw_frame=%b run=%b exp 1/0", saw, game_run);
        end
        wait_sof(found);
        tick();
        checks++;
        if (!found || screen_sel !== 2'b00) begin
            errors++; $display("FAIL screen_title got=%b exp=00", screen_sel);
        end
    endtask

    task automatic test_continue();
        int ng0, cg0;
        exp_q.push_back(4'd1);
        coin_pulse();
        repeat (15) tick();
        start_pulse();
        exp_q.push_back(4'd1);
        coin_pulse();
        repeat (15) tick();
        player_dead = 1'b1;
        tick();
        player_dead = 1'b0;
        repeat (30) tick();
        ng0 = ng_cnt;
        cg0 = cg_cnt;
        start_pulse();
        checks++;
        if (cg_cnt - cg0 !== 1 || ng_cnt != ng0 || credits !== 4'd0 || game_run !== 1'b1) begin
            errors++; $display("FAIL continue cg=%0d ng=%0d credits=%0d run=%b exp 1/0/0/1",
                               cg_cnt - cg0, ng_cnt - ng0, credits, game_run);
        end
        exp_q.push_back(4'd1);
        coin_pulse();
        repeat (15) tick();
        player_dead = 1'b1;
        tick();
        player_dead = 1'b0;
        repeat (78) tick();
        checks++;
        if (continue_sec !== 4'd0 || game_run !== 1'b0) begin
            errors++; $display("FAIL pre_expiry sec=%0d run=%b exp 0/0", continue_sec, game_run);
        end
        cg0 = cg_cnt;
        start_pulse();
        repeat (5) tick();
        checks++;
        if (cg_cnt - cg0 !== 1 || game_run !== 1'b1 || credits !== 4'd0) begin
            errors++; $display("FAIL start_vs_expiry cg=%0d run=%b credits=%0d exp 1/1/0", cg_cnt - cg0, game_run, credits);
        end
    endtask

    task automatic test_free_play();
        int ep0, ng0;
        do_reset();
        mode_arcade = 1'b0;
        ep0 = ep_cnt;
        ng0 = ng_cnt;
        coin_pulse();
        repeat (15) tick();
        checks++;
        if (credits !== 4'd0 || ep_cnt != ep0) begin
            errors++; $display("FAIL free_coin credits=%0d pulses=%0d exp 0/0", credits, ep_cnt - ep0);
        end
        start_pulse();
        checks++;
        if (ng_cnt - ng0 !== 1 || credits !== 4'd0 || game_run !== 1'b1) begin
            errors++; $display("FAIL free_start ng=%0d credits=%0d run=%b exp 1/0/1", ng_cnt - ng0, credits, game_run);
        end
        mode_arcade = 1'b1;
    endtask

    task automatic test_reset_mid();
        int ep0;
        do_reset();
        exp_q.push_back(4'd1);
        coin_pulse();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({e_piece, credits, game_run, new_game, continue_game, screen_sel, continue_sec} !== 14'd0) begin
            errors++; $display("FAIL reset_anim got=%b exp=0",
                               {e_piece, credits, game_run, new_game, continue_game, screen_sel, continue_sec});
        end
        reset = 1'b0;
        ep0 = ep_cnt;
        exp_q.push_back(4'd1);
        coin_pulse();
        checks++;
        if (ep_cnt - ep0 !== 1 || credits !== 4'd1) begin
            errors++; $display("FAIL coin_after_reset pulses=%0d credits=%0d exp 1/1", ep_cnt - ep0, credits);
        end
        repeat (15) tick();
        start_pulse();
        player_dead = 1'b1;
        tick();
        player_dead = 1'b0;
        repeat (10) tick();
        checks++;
        if (continue_sec !== 4'd3) begin
            errors++; $display("FAIL countdown_live got=%0d exp=3", continue_sec);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({e_piece, credits, game_run, new_game, continue_game, screen_sel, continue_sec} !== 14'd0) begin
            errors++; $display("FAIL reset_countdown got=%b exp=0",
                               {e_piece, credits, game_run, new_game, continue_game, screen_sel, continue_sec});
        end
        reset = 1'b0;
        ep0 = ep_cnt;
        exp_q.push_back(4'd1);
        coin_pulse();
        checks++;
        if (ep_cnt - ep0 !== 1 || credits !== 4'd1 || exp_q.size() != 0) begin
            errors++; $display("FAIL coin_after_reset2 pulses=%0d credits=%0d exp 1/1", ep_cnt - ep0, credits);
        end
    endtask

    initial begin
        reset       = 1'b1;
        coin_in     = 1'b0;
        start_req   = 1'b0;
        player_dead = 1'b0;
        mode_arcade = 1'b1;
        test_reset();
        test_coin_hold();
        test_coin_lockout();
        test_start_gate();
        test_countdown();
        test_continue();
        test_free_play();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
